// File: rtl/btn_uart_pkg.sv
// Shared types, constants and helpers for the button-to-UART reporter.
// Defining BTN_UART_PARITY_EN adds the PARITY state to tx_state_t.
package btn_uart_pkg;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam int unsigned REPEAT_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef BTN_UART_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per UART bit, truncated.
    function automatic int unsigned calc_bit_cycles(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser followed by a saturating-difference
// debounce counter that flips the stable level after DB_CYCLES of disagreement.
module btn_debounce_ch #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/btn_uart_reporter.sv
// Debounces N_BTN buttons and reports the stable vector as UART bytes on change
// and at a hold-repeat rate. Define BTN_UART_PARITY_EN for an even-parity bit.
module btn_uart_reporter
    import btn_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BAUD          = 115_200,
    parameter int unsigned N_BTN         = 2,
    parameter int unsigned DB_CYCLES     = 1_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_db,
    output logic             TxD,
    output logic             busy
);

    localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned BAUD_W     = $clog2(BIT_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam int unsigned REP_MAX    = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam int unsigned REP_W      = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_MAX);
    localparam int unsigned IDX_W      = $clog2(FRAME_DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA_BITS - 1);

    logic [N_BTN-1:0]           db_vec;
    logic [N_BTN-1:0]           db_prev_q, db_prev_d;
    logic [REP_W-1:0]           rep_q, rep_d;
    logic                       pend_q, pend_d;
    logic                       pend_chg_q, pend_chg_d;
    tx_state_t                  state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [FRAME_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                       txd_q, txd_d;
    logic                       busy_q, busy_d;
`ifdef BTN_UART_PARITY_EN
    logic                       par_q, par_d;
`endif

    logic                       change_c;
    logic                       rep_hit_c;
    logic                       chg_any_c;
    logic                       frame_start_c;
    logic                       baud_last_c;
    logic [FRAME_DATA_BITS-1:0] byte_c;

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn[i]),
            .stable  (db_vec[i])
        );
    end

    // Triggers, pending flags, repeat timer and the frame snapshot byte.
    always_comb begin
        change_c      = (db_vec != db_prev_q);
        rep_hit_c     = (REPEAT_CYCLES != 0) && (db_vec != '0) && (rep_q == REP_LAST);
        chg_any_c     = pend_chg_q | change_c;
        frame_start_c = (state_q == IDLE) && (pend_q | change_c | rep_hit_c);
        db_prev_d     = db_vec;
        pend_d        = pend_q | change_c | rep_hit_c;
        pend_chg_d    = chg_any_c;
        if (frame_start_c) begin
            pend_d     = 1'b0;
            pend_chg_d = 1'b0;
        end

        if ((REPEAT_CYCLES == 0) || (db_vec == '0) || change_c || frame_start_c || rep_hit_c) begin
            rep_d = '0;
        end else begin
            rep_d = rep_q + REP_W'(1);
        end

        byte_c                  = '0;
        byte_c[N_BTN-1:0]       = db_vec;
        byte_c[REPEAT_FLAG_BIT] = ~chg_any_c;
    end

    // Transmit FSM; TxD and busy are registered from the next-state view.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
`ifdef BTN_UART_PARITY_EN
        par_d       = par_q;
`endif
        baud_last_c = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = baud_last_c ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (frame_start_c) begin
                    state_d = START;
                    baud_d  = '0;
                    idx_d   = '0;
                    shreg_d = byte_c;
`ifdef BTN_UART_PARITY_EN
                    par_d   = ^byte_c;
`endif
                end
            end
            START: begin
                if (baud_last_c) state_d = DATA;
            end
            DATA: begin
                if (baud_last_c) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef BTN_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef BTN_UART_PARITY_EN
            PARITY: begin
                if (baud_last_c) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_last_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
`ifdef BTN_UART_PARITY_EN
            PARITY:  txd_d = par_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            db_prev_q  <= '0;
            rep_q      <= '0;
            pend_q     <= 1'b0;
            pend_chg_q <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
`ifdef BTN_UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            db_prev_q  <= db_prev_d;
            rep_q      <= rep_d;
            pend_q     <= pend_d;
            pend_chg_q <= pend_chg_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
`ifdef BTN_UART_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign btn_db = db_vec;
    assign TxD    = txd_q;
    assign busy   = busy_q;

endmodule

// File: doc/btn_uart_reporter.md
# btn_uart_reporter

Parametrised successor to the two-button paddle front end: debounces N_BTN raw button inputs and reports their state to the host PC as 8N1 UART bytes. A byte is sent whenever the debounced vector changes, and again at a fixed hold-repeat rate while any button stays pressed. It sits directly under the game top and replaces the separate per-button debounce and transmit instances.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate. BIT_CYCLES = CLK_HZ / BAUD, truncated, and must be ≥ 2.
- N_BTN, 2, number of button channels, 1..7.
- DB_CYCLES, 1_000_000, cycles the synchronised input must differ from the stable value before the stable value updates. Must be ≥ 1.
- REPEAT_CYCLES, 10_000_000, hold-repeat period in cycles. A value of 0 disables repeat.
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset. Synchronous, active-low.
- btn  in  N_BTN  raw asynchronous button inputs, 1 = pressed.
- btn_db  out  N_BTN  debounced stable state.
- TxD  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is on the line (START through STOP).

## Operation
- **Synchroniser:** each btn bit passes through a 2-FF synchroniser.
- **Debounce (per channel):**
  - A counter increments while the synchronised input differs from stable, and clears when they are equal.
  - When the counter reaches DB_CYCLES-1 while still differing, stable toggles and the counter clears.
- **Triggers:**
  - change: btn_db differs from its value on the previous cycle.
  - repeat: enabled only when REPEAT_CYCLES > 0. The repeat timer runs while btn_db != 0 and clears on any change, on frame start, and while btn_db == 0. When it reaches REPEAT_CYCLES-1, a repeat request is raised.
- **Pending flag:**
  - Any trigger sets pend; a change trigger also sets pend_chg.
  - Triggers arriving while busy are merged into pend. Only one frame is ever queued.
- **Frame byte (snapshot taken at frame start):**
  - bits [N_BTN-1:0] = btn_db.
  - bits [6:N_BTN] = 0.
  - bit 7 = 1 if the frame was caused only by repeat, 0 if any change contributed.
  - A change and a repeat on the same cycle produce bit 7 = 0.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE → START when pend = 1. pend and pend_chg clear and the byte is latched.
  - START drives 0 for BIT_CYCLES, then → DATA.
  - DATA shifts 8 bits LSB first, BIT_CYCLES each. A bit index 0..7 wraps to exit → PARITY or STOP.
  - STOP drives 1 for BIT_CYCLES, then → IDLE.
- **Reset values:** TxD = 1, busy = 0, btn_db = 0, all counters 0, pend = 0, FSM = IDLE.
  - Reset mid-frame returns TxD to 1 on the next clock, truncating the frame.

## Timing
- Debounce latency: a btn level held from cycle t is seen in btn_db at t + 2 + DB_CYCLES.
- Frame start: in the cycle after pend is set in IDLE, the FSM enters START, TxD = 0 and busy = 1.
- Frame length: 10·BIT_CYCLES cycles, or 11·BIT_CYCLES with parity. busy falls in the cycle after the last STOP cycle.
- Back-to-back frames: a pending frame starts after exactly one IDLE cycle following STOP.
- Pulses shorter than DB_CYCLES never change btn_db.

## Configuration
- BTN_UART_PARITY_EN defined:
  - PARITY state inserted after DATA.
  - Drives even parity (XOR of the 8 data bits) for BIT_CYCLES.
  - Frame = 11 bit periods.
- Undefined: no PARITY state, 10 bit periods, plain 8N1.

## Structure
- Package btn_uart_pkg:
  - tx_state_t enum.
  - FRAME_DATA_BITS = 8.
  - REPEAT_FLAG_BIT = 7.
  - Function computing BIT_CYCLES from CLK_HZ/BAUD.
- Sub-module btn_debounce_ch: one channel (synchroniser + counter), instantiated N_BTN times via generate.

## Test plan
Bench parameters: CLK_HZ=1000, BAUD=100 (BIT_CYCLES=10), N_BTN=2, DB_CYCLES=4, REPEAT_CYCLES=200.
1. Reset: hold rst=0 for 3 cycles → TxD=1, busy=0, btn_db=00. Release with btn=00 → no frame for 500 cycles.
2. Press btn[0] held → btn_db=01 after 6 cycles. Next cycle TxD=0, then data 0x01 LSB first, then stop. busy high for 100 cycles.
3. btn[1] glitch of 3 cycles → btn_db unchanged, no frame.
4. Hold btn=01 after the change frame → repeat frames with byte 0x81 every 200 cycles measured frame-start to frame-start.
5. btn[1] pressed mid-frame → the current frame completes unchanged, one IDLE cycle follows, then byte 0x03.
6. Build with BTN_UART_PARITY_EN and press btn=11 → byte 0x03, parity bit 0, frame 110 cycles. Assert rst=0 mid-DATA → TxD=1 and busy=0 next cycle.
